// File: rtl/uart_pkg.sv
// Shared register map, response codes and FSM state types for the AXI4-Lite UART.
package uart_pkg;

    localparam logic [3:0] TXDATA_OFS = 4'h0;
    localparam logic [3:0] RXDATA_OFS = 4'h4;
    localparam logic [3:0] STATUS_OFS = 4'h8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int STAT_TX_BUSY    = 0;
    localparam int STAT_RX_VALID   = 1;
    localparam int STAT_RX_OVERRUN = 2;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

endpackage

// File: rtl/uart_rx.sv
// 8N1 receiver: 2-FF synchroniser, mid-bit sampling, one-cycle byte_valid strobe.
//  state    | meaning
//  RX_IDLE  | waiting for a falling edge on the synchronised line
//  RX_START | half a bit in, recheck the line is still low
//  RX_DATA  | sampling 8 data bits at mid-bit, LSB first
//  RX_STOP  | sampling the stop bit; high delivers the byte, low drops it
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_dser,
    output logic       byte_valid,
    output logic [7:0] rx_data
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic             sync_ff1;
    logic             sync_ff2;
    logic             rx_prev;
    rx_state_t        state;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       shift_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_ff1 <= 1'b1;
            sync_ff2 <= 1'b1;
            rx_prev  <= 1'b1;
        end else begin
            sync_ff1 <= rx_dser;
            sync_ff2 <= sync_ff1;
            rx_prev  <= sync_ff2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RX_IDLE;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            byte_valid <= 1'b0;
            rx_data    <= '0;
        end else begin
            byte_valid <= 1'b0;
            case (state)
                RX_IDLE: begin
                    if (rx_prev && !sync_ff2) begin
                        state    <= RX_START;
                        baud_cnt <= HALF_BIT;
                    end
                end
                RX_START: begin
                    if (baud_cnt != '0) begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end else if (!sync_ff2) begin
                        state    <= RX_DATA;
                        baud_cnt <= FULL_BIT;
                        bit_cnt  <= '0;
                    end else begin
                        state <= RX_IDLE;
                    end
                end
                RX_DATA: begin
                    if (baud_cnt != '0) begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end else begin
                        shift_reg <= {sync_ff2, shift_reg[7:1]};
                        baud_cnt  <= FULL_BIT;
                        if (bit_cnt == 3'd7) begin
                            state <= RX_STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                RX_STOP: begin
                    if (baud_cnt != '0) begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end else begin
                        // A low stop bit is a framing error: the byte is silently dropped.
                        if (sync_ff2) begin
                            rx_data    <= shift_reg;
                            byte_valid <= 1'b1;
                        end
                        state <= RX_IDLE;
                    end
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/axi_uart.sv
// AXI4-Lite UART: TX engine, register decode and the single-byte receive buffer.
//  state    | meaning
//  TX_IDLE  | line high, ready to accept a TXDATA write
//  TX_START | driving the start bit
//  TX_DATA  | shifting 8 data bits LSB first
//  TX_STOP  | driving the stop bit
module axi_uart
    import uart_pkg::*;
#(
    parameter int AXI_AWIDTH   = 4,
    parameter int AXI_DWIDTH   = 32,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic                    AXI_ACLK,
    input  logic                    AXI_ARESETN,
    input  logic [AXI_AWIDTH-1:0]   AXI_AWADDR,
    input  logic                    AXI_AWVALID,
    output logic                    AXI_AWREADY,
    input  logic [AXI_DWIDTH-1:0]   AXI_WDATA,
    input  logic [AXI_DWIDTH/8-1:0] AXI_WSTRB,
    input  logic                    AXI_WVALID,
    output logic                    AXI_WREADY,
    output logic [1:0]              AXI_BRESP,
    output logic                    AXI_BVALID,
    input  logic                    AXI_BREADY,
    input  logic [AXI_AWIDTH-1:0]   AXI_ARADDR,
    input  logic                    AXI_ARVALID,
    output logic                    AXI_ARREADY,
    output logic [AXI_DWIDTH-1:0]   AXI_RDATA,
    output logic [1:0]              AXI_RRESP,
    output logic                    AXI_RVALID,
    input  logic                    AXI_RREADY,
    input  logic                    RX_DSER,
    output logic                    TX_DSER
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(CLKS_PER_BIT - 1);

    logic                  wr_accept;
    logic                  wr_fire;
    logic [3:0]            wr_addr;
    logic [1:0]            wr_resp;
    logic                  tx_start;
    logic                  rd_accept;
    logic                  rd_fire;
    logic [3:0]            rd_addr;
    logic [AXI_DWIDTH-1:0] rd_data;
    logic [1:0]            rd_resp;
    logic                  rx_pop;
    logic                  ovr_clear;

    tx_state_t             tx_state;
    logic [CNT_W-1:0]      tx_cnt;
    logic [2:0]            tx_bit_cnt;
    logic [7:0]            tx_shift;
    logic                  tx_busy;

    logic                  rx_new_valid;
    logic [7:0]            rx_new_byte;
    logic [7:0]            rx_byte;
    logic                  rx_valid;
    logic                  rx_overrun;

    logic                  unused_bits;

    assign unused_bits = ^{AXI_AWADDR, AXI_ARADDR, AXI_WDATA, AXI_WSTRB};

    assign AXI_AWREADY = wr_accept;
    assign AXI_WREADY  = wr_accept;
    assign AXI_ARREADY = rd_accept;
    assign wr_fire     = wr_accept && AXI_AWVALID && AXI_WVALID;
    assign rd_fire     = rd_accept && AXI_ARVALID;
    assign wr_addr     = {AXI_AWADDR[3:2], 2'b00};
    assign rd_addr     = {AXI_ARADDR[3:2], 2'b00};
    assign tx_busy     = (tx_state != TX_IDLE);

    always_comb begin
        wr_resp  = RESP_OKAY;
        tx_start = 1'b0;
        case (wr_addr)
            TXDATA_OFS: begin
                if (AXI_WSTRB[0]) begin
                    if (tx_busy) begin
                        wr_resp = RESP_SLVERR;
                    end else begin
                        tx_start = wr_fire;
                    end
                end
            end
            RXDATA_OFS, STATUS_OFS: wr_resp = RESP_OKAY;
            default:                wr_resp = RESP_SLVERR;
        endcase
    end

    always_comb begin
        rd_data   = '0;
        rd_resp   = RESP_OKAY;
        rx_pop    = 1'b0;
        ovr_clear = 1'b0;
        case (rd_addr)
            TXDATA_OFS: rd_data = '0;
            RXDATA_OFS: begin
                rd_data[7:0] = rx_byte;
                rx_pop       = rd_fire && rx_valid;
            end
            STATUS_OFS: begin
                rd_data[STAT_TX_BUSY]    = tx_busy;
                rd_data[STAT_RX_VALID]   = rx_valid;
                rd_data[STAT_RX_OVERRUN] = rx_overrun;
                ovr_clear                = rd_fire;
            end
            default: rd_resp = RESP_SLVERR;
        endcase
    end

    // Ready pulses for one cycle; the !ready term stops a held valid from double-accepting.
    always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
        if (!AXI_ARESETN) begin
            wr_accept  <= 1'b0;
            AXI_BVALID <= 1'b0;
            AXI_BRESP  <= RESP_OKAY;
        end else begin
            wr_accept <= AXI_AWVALID && AXI_WVALID && !AXI_BVALID && !wr_accept;
            if (wr_fire) begin
                AXI_BVALID <= 1'b1;
                AXI_BRESP  <= wr_resp;
            end else if (AXI_BVALID && AXI_BREADY) begin
                AXI_BVALID <= 1'b0;
            end
        end
    end

    always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
        if (!AXI_ARESETN) begin
            rd_accept  <= 1'b0;
            AXI_RVALID <= 1'b0;
            AXI_RDATA  <= '0;
            AXI_RRESP  <= RESP_OKAY;
        end else begin
            rd_accept <= AXI_ARVALID && !AXI_RVALID && !rd_accept;
            if (rd_fire) begin
                AXI_RVALID <= 1'b1;
                AXI_RDATA  <= rd_data;
                AXI_RRESP  <= rd_resp;
            end else if (AXI_RVALID && AXI_RREADY) begin
                AXI_RVALID <= 1'b0;
            end
        end
    end

    always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
        if (!AXI_ARESETN) begin
            tx_state   <= TX_IDLE;
            tx_cnt     <= '0;
            tx_bit_cnt <= '0;
            tx_shift   <= '0;
            TX_DSER    <= 1'b1;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    if (tx_start) begin
                        tx_state <= TX_START;
                        tx_cnt   <= FULL_BIT;
                        tx_shift <= AXI_WDATA[7:0];
                        TX_DSER  <= 1'b0;
                    end
                end
                TX_START: begin
                    if (tx_cnt != '0) begin
                        tx_cnt <= tx_cnt - 1'b1;
                    end else begin
                        tx_state   <= TX_DATA;
                        tx_cnt     <= FULL_BIT;
                        tx_bit_cnt <= '0;
                        TX_DSER    <= tx_shift[0];
                    end
                end
                TX_DATA: begin
                    if (tx_cnt != '0) begin
                        tx_cnt <= tx_cnt - 1'b1;
                    end else begin
                        tx_cnt <= FULL_BIT;
                        if (tx_bit_cnt == 3'd7) begin
                            tx_state <= TX_STOP;
                            TX_DSER  <= 1'b1;
                        end else begin
                            tx_bit_cnt <= tx_bit_cnt + 1'b1;
                            tx_shift   <= {1'b0, tx_shift[7:1]};
                            TX_DSER    <= tx_shift[1];
                        end
                    end
                end
                TX_STOP: begin
                    if (tx_cnt != '0) begin
                        tx_cnt <= tx_cnt - 1'b1;
                    end else begin
                        tx_state <= TX_IDLE;
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

    uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart_rx (
        .clk       (AXI_ACLK),
        .rst_n     (AXI_ARESETN),
        .rx_dser   (RX_DSER),
        .byte_valid(rx_new_valid),
        .rx_data   (rx_new_byte)
    );

    // A pop coinciding with a new byte is not an overrun: the old byte was consumed.
    always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
        if (!AXI_ARESETN) begin
            rx_byte    <= '0;
            rx_valid   <= 1'b0;
            rx_overrun <= 1'b0;
        end else if (rx_new_valid) begin
            rx_byte    <= rx_new_byte;
            rx_valid   <= 1'b1;
            rx_overrun <= (rx_valid && !rx_pop) || (rx_overrun && !ovr_clear);
        end else begin
            if (rx_pop) begin
                rx_valid <= 1'b0;
            end
            if (ovr_clear) begin
                rx_overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axi_uart.sv
// Directed/randomised bench for axi_uart with a byte-level model of the UART registers.
module tb_axi_uart;

    localparam int CPB = 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  awaddr = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    logic [3:0]  araddr = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b0;
    logic        rx = 1'b1;
    logic        tx;

    int cyc = 0;
    int n_assert = 0;
    int n_fail = 0;

    logic [7:0] m_byte = 8'h00;
    logic       m_valid = 1'b0;
    logic       m_ovr = 1'b0;
    logic       tx_at_hs;

    axi_uart #(
        .AXI_AWIDTH  (4),
        .AXI_DWIDTH  (32),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .AXI_ACLK   (clk),
        .AXI_ARESETN(rst_n),
        .AXI_AWADDR (awaddr),
        .AXI_AWVALID(awvalid),
        .AXI_AWREADY(awready),
        .AXI_WDATA  (wdata),
        .AXI_WSTRB  (wstrb),
        .AXI_WVALID (wvalid),
        .AXI_WREADY (wready),
        .AXI_BRESP  (bresp),
        .AXI_BVALID (bvalid),
        .AXI_BREADY (bready),
        .AXI_ARADDR (araddr),
        .AXI_ARVALID(arvalid),
        .AXI_ARREADY(arready),
        .AXI_RDATA  (rdata),
        .AXI_RRESP  (rresp),
        .AXI_RVALID (rvalid),
        .AXI_RREADY (rready),
        .RX_DSER    (rx),
        .TX_DSER    (tx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp, output int hs);
        int n = 0;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
        while (!awready && n < 20) begin
            tick(1);
            n++;
        end
        check("aw_handshake_in_time", 32'(n < 20), 1);
        check("wready_with_awready", wready, awready);
        tick(1);
        hs = cyc;
        tx_at_hs = tx;
        awvalid = 1'b0; wvalid = 1'b0;
        check("awready_one_cycle", awready, 0);
        check("bvalid_after_hs", bvalid, 1);
        tick(1);
        check("bvalid_holds", bvalid, 1);
        resp = bresp;
        bready = 1'b1;
        tick(1);
        bready = 1'b0;
        check("bvalid_drop", bvalid, 0);
    endtask

    task automatic axi_read(input logic [3:0] a, output logic [31:0] d, output logic [1:0] resp);
        int n = 0;
        araddr = a; arvalid = 1'b1;
        while (!arready && n < 20) begin
            tick(1);
            n++;
        end
        check("ar_handshake_in_time", 32'(n < 20), 1);
        tick(1);
        arvalid = 1'b0;
        check("arready_one_cycle", arready, 0);
        check("rvalid_after_hs", rvalid, 1);
        d = rdata;
        resp = rresp;
        rready = 1'b1;
        tick(1);
        rready = 1'b0;
        check("rvalid_drop", rvalid, 0);
    endtask

    task automatic read_status(input logic busy, input string tag);
        logic [31:0] d;
        logic [1:0]  r;
        axi_read(4'h8, d, r);
        check(tag, d, {29'b0, m_ovr, m_valid, busy});
        check({tag, "_resp"}, 32'(r), 32'(2'b00));
        m_ovr = 1'b0;
    endtask

    task automatic read_rxdata(input string tag);
        logic [31:0] d;
        logic [1:0]  r;
        axi_read(4'h4, d, r);
        check(tag, d, {24'b0, m_byte});
        check({tag, "_resp"}, 32'(r), 32'(2'b00));
        m_valid = 1'b0;
    endtask

    task automatic drive_rx(input logic [7:0] b, input logic stop_bit);
        logic [9:0] frame;
        frame = {stop_bit, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            rx = frame[k];
            tick(CPB);
        end
        rx = 1'b1;
        tick(CPB);
        if (stop_bit) begin
            if (m_valid) m_ovr = 1'b1;
            m_valid = 1'b1;
            m_byte  = b;
        end
    endtask

    task automatic check_tx_frame(input logic [7:0] b, input int hs, input string tag);
        logic [9:0] frame;
        frame = {1'b1, b, 1'b0};
        check({tag, "_falls_at_hs"}, tx_at_hs, 0);
        for (int k = 0; k < 10; k++) begin
            wait_until(hs + k * CPB + 1);
            check($sformatf("%s_bit%0d_early", tag, k), tx, frame[k]);
            wait_until(hs + k * CPB + CPB - 1);
            check($sformatf("%s_bit%0d_late", tag, k), tx, frame[k]);
        end
        wait_until(hs + 10 * CPB + 1);
        check({tag, "_idle_after"}, tx, 1);
    endtask

    initial begin
        logic [1:0]  resp;
        logic [31:0] d;
        logic [7:0]  b;
        int          hs;
        int          hs2;

        tick(3);
        check("rst_awready", awready, 0);
        check("rst_wready", wready, 0);
        check("rst_arready", arready, 0);
        check("rst_bvalid", bvalid, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_bresp", 32'(bresp), 0);
        check("rst_rresp", 32'(rresp), 0);
        check("rst_rdata", rdata, 0);
        check("rst_tx", tx, 1);
        rst_n = 1'b1;
        tick(2);
        read_status(1'b0, "status_after_reset");

        // Transmit 0xA5 and watch the whole frame
        axi_write(4'h0, 32'h0000_00A5, 4'h1, resp, hs);
        check("tx_a5_bresp", 32'(resp), 32'(2'b00));
        read_status(1'b1, "status_busy_a5");
        check_tx_frame(8'hA5, hs, "tx_a5");
        read_status(1'b0, "status_idle_a5");

        // Second write while busy is refused; only 0x55 goes out
        axi_write(4'h0, 32'h0000_0055, 4'h1, resp, hs);
        check("tx_55_bresp", 32'(resp), 32'(2'b00));
        axi_write(4'h0, 32'h0000_00AA, 4'h1, resp, hs2);
        check("tx_busy_bresp", 32'(resp), 32'(2'b10));
        check_tx_frame(8'h55, hs, "tx_55");
        tick(2 * CPB);
        check("tx_no_second_frame", tx, 1);
        read_status(1'b0, "status_after_55");

        for (int i = 0; i < 2; i++) begin
            b = 8'($urandom_range(0, 255));
            axi_write(4'h0, {$urandom, 8'h00} | 32'(b), 4'h1, resp, hs);
            check($sformatf("tx_rand%0d_bresp", i), 32'(resp), 32'(2'b00));
            check_tx_frame(b, hs, $sformatf("tx_rand%0d", i));
        end

        // Writes that must not start a frame
        axi_write(4'h0, 32'h0000_0033, 4'h0, resp, hs);
        check("tx_nostrb_bresp", 32'(resp), 32'(2'b00));
        read_status(1'b0, "status_nostrb");
        check("tx_nostrb_line", tx, 1);
        axi_write(4'h4, 32'h0000_0012, 4'hF, resp, hs);
        check("wr_rxdata_bresp", 32'(resp), 32'(2'b00));
        axi_write(4'h8, 32'h0000_0007, 4'hF, resp, hs);
        check("wr_status_bresp", 32'(resp), 32'(2'b00));
        axi_write(4'hC, 32'h0000_0044, 4'hF, resp, hs);
        check("wr_unmapped_bresp", 32'(resp), 32'(2'b10));
        read_status(1'b0, "status_after_dropped_writes");
        check("tx_line_after_dropped", tx, 1);

        // Receive path
        drive_rx(8'h3C, 1'b1);
        read_status(1'b0, "status_rx_3c");
        read_rxdata("rxdata_3c");
        read_status(1'b0, "status_after_pop_3c");

        drive_rx(8'h11, 1'b1);
        drive_rx(8'h22, 1'b1);
        read_status(1'b0, "status_overrun");
        read_status(1'b0, "status_overrun_cleared");
        read_rxdata("rxdata_22");
        read_status(1'b0, "status_after_pop_22");

        for (int i = 0; i < 3; i++) begin
            b = 8'($urandom_range(0, 255));
            drive_rx(b, 1'b1);
            if (i == 1) begin
                read_status(1'b0, $sformatf("status_rand%0d", i));
            end
            read_rxdata($sformatf("rxdata_rand%0d", i));
        end

        // Framing error: byte dropped, no flag
        drive_rx(8'h5A, 1'b0);
        read_status(1'b0, "status_framing");
        read_rxdata("rxdata_after_framing");

        // Short glitch on the line
        rx = 1'b0;
        tick(CPB / 4);
        rx = 1'b1;
        tick(2 * CPB);
        read_status(1'b0, "status_glitch");
        read_rxdata("rxdata_empty");

        axi_read(4'hC, d, resp);
        check("rd_unmapped_data", d, 0);
        check("rd_unmapped_rresp", 32'(resp), 32'(2'b10));
        axi_read(4'h0, d, resp);
        check("rd_txdata_data", d, 0);
        check("rd_txdata_rresp", 32'(resp), 32'(2'b00));

        // Reset in the middle of a frame
        drive_rx(8'h9E, 1'b1);
        axi_write(4'h0, 32'h0000_00F0, 4'h1, resp, hs);
        wait_until(hs + 3 * CPB + 5);
        check("tx_f0_mid_frame_low", tx, 0);
        rst_n = 1'b0;
        #1;
        check("rst_mid_tx_line", tx, 1);
        check("rst_mid_bvalid", bvalid, 0);
        check("rst_mid_rvalid", rvalid, 0);
        tick(3);
        rst_n = 1'b1;
        m_valid = 1'b0;
        m_ovr = 1'b0;
        m_byte = 8'h00;
        tick(2);
        read_status(1'b0, "status_after_mid_reset");
        read_rxdata("rxdata_after_mid_reset");
        tick(12 * CPB);
        check("tx_idle_after_mid_reset", tx, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
